// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and defaults for the data-memory access controller.
//   DATA_W          data word width
//   WAIT_CYCLES_DEF default number of cycles each access holds the memory strobes
//   BASE_ADDR_DEF   default byte address that maps to memory word 0
//   CNT_W           width of the wait-state counter
//   state_t         controller FSM states (loader states only with MEM_ACCESS_CTRL_LOADER_EN)
package mem_ctrl_pkg;

  localparam int          DATA_W          = 32;
  localparam int          WAIT_CYCLES_DEF = 4;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;
  localparam int          CNT_W           = 4;

`ifdef MEM_ACCESS_CTRL_LOADER_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PIPE  = 3'd1,
    ST_PDONE = 3'd2,
    ST_LD    = 3'd3,
    ST_LDONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PIPE  = 3'd1,
    ST_PDONE = 3'd2
  } state_t;
`endif

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter that times memory wait states.
//   clk, rst  clock / asynchronous active-high reset
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       decrement by one
//   cnt       current count
//   zero      count is zero
module mem_wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto the single-port data
// memory, holding the strobes for WAIT_CYCLES cycles and freezing the pipeline
// until the access is done. With MEM_ACCESS_CTRL_LOADER_EN defined a loader/debug
// port shares the memory, alternating fairly with the pipeline.
//   pipe_r_en/pipe_w_en/pipe_addr/pipe_wdata  MEM-stage request (byte address)
//   pipe_rdata                                registered load data
//   freeze                                    stall pipeline (combinational)
//   ld_req/ld_we/ld_addr/ld_wdata             loader request (word address, macro only)
//   ld_rdata/ld_done                          loader read data / completion pulse
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata memory array interface
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 11,
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_r_en,
  input  logic              pipe_w_en,
  input  logic [31:0]       pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              freeze,
`ifdef MEM_ACCESS_CTRL_LOADER_EN
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_done,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [DATA_W-1:0] pipe_rdata_q, pipe_rdata_d;

  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;

  logic              pipe_req;
  logic              ld_wins;
  logic [31:0]       addr_diff;
  logic [ADDR_W-1:0] pipe_word;
  logic              unused_addr_bits;

  assign pipe_req  = pipe_r_en | pipe_w_en;
  // Out-of-window addresses simply wrap modulo the memory size.
  assign addr_diff = pipe_addr - BASE_ADDR;
  assign pipe_word = addr_diff[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr_diff[31:ADDR_W+2], addr_diff[1:0], cnt_val};

`ifdef MEM_ACCESS_CTRL_LOADER_EN
  logic              ld_turn_q, ld_turn_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              ld_done_q, ld_done_d;

  // Loader pre-empts a waiting pipe request only when it is its turn.
  assign ld_wins = ld_req & ld_turn_q;
`else
  assign ld_wins = 1'b0;
`endif

  mem_wait_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    pipe_rdata_d = pipe_rdata_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
`ifdef MEM_ACCESS_CTRL_LOADER_EN
    ld_turn_d    = ld_turn_q;
    ld_rdata_d   = ld_rdata_q;
    ld_done_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pipe_req && !ld_wins) begin
          // A simultaneous read+write request is performed as a write.
          state_d     = ST_PIPE;
          we_d        = pipe_w_en;
          mem_addr_d  = pipe_word;
          mem_wdata_d = pipe_wdata;
          mem_we_d    = pipe_w_en;
          mem_re_d    = !pipe_w_en;
          cnt_load    = 1'b1;
        end
`ifdef MEM_ACCESS_CTRL_LOADER_EN
        else if (ld_req) begin
          state_d     = ST_LD;
          we_d        = ld_we;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_wdata;
          mem_we_d    = ld_we;
          mem_re_d    = !ld_we;
          cnt_load    = 1'b1;
          ld_turn_d   = 1'b0;
        end
`endif
      end
      ST_PIPE: begin
        if (cnt_zero) begin
          state_d = ST_PDONE;
          if (!we_q) pipe_rdata_d = mem_rdata;
`ifdef MEM_ACCESS_CTRL_LOADER_EN
          if (ld_req) ld_turn_d = 1'b1;
`endif
        end else begin
          cnt_dec  = 1'b1;
          mem_we_d = we_q;
          mem_re_d = !we_q;
        end
      end
      ST_PDONE: state_d = ST_IDLE;
`ifdef MEM_ACCESS_CTRL_LOADER_EN
      ST_LD: begin
        if (cnt_zero) begin
          state_d   = ST_LDONE;
          ld_done_d = 1'b1;
          if (!we_q) ld_rdata_d = mem_rdata;
        end else begin
          cnt_dec  = 1'b1;
          mem_we_d = we_q;
          mem_re_d = !we_q;
        end
      end
      ST_LDONE: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      pipe_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      pipe_rdata_q <= pipe_rdata_d;
    end
  end

`ifdef MEM_ACCESS_CTRL_LOADER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_turn_q  <= 1'b0;
      ld_rdata_q <= '0;
      ld_done_q  <= 1'b0;
    end else begin
      ld_turn_q  <= ld_turn_d;
      ld_rdata_q <= ld_rdata_d;
      ld_done_q  <= ld_done_d;
    end
  end

  assign ld_rdata = ld_rdata_q;
  assign ld_done  = ld_done_q;
`endif

  // Pipeline is released during exactly the completion cycle of its own access.
  assign freeze     = pipe_req && (state_q != ST_PDONE);
  assign pipe_rdata = pipe_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing and arbitration controller for the shared single-port data memory in the processor datapath. Accepts byte-addressed load/store requests from the MEM pipeline stage, stretches each access over a fixed number of memory wait states, and freezes the pipeline until data is returned. An optional loader/debug port shares the same memory under fair arbitration. Sits between the MEM stage and the word-organised data memory array.

## Interface
- ADDR_W, 11, memory word-address width (2048 words)
- WAIT_CYCLES, 4, cycles each access holds the memory strobes; legal range 1..15
- BASE_ADDR, 32'd1024, byte address mapped to memory word 0

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pipe_r_en  in  1  MEM-stage load request
- pipe_w_en  in  1  MEM-stage store request
- pipe_addr  in  32  byte address (ALU result)
- pipe_wdata  in  32  store data (Val_Rm)
- pipe_rdata  out  32  load data, registered
- freeze  out  1  stall all pipeline registers up to and including MEM/WB
- ld_req  in  1  loader request, level, held until ld_done (macro only)
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  32  loader write data
- ld_rdata  out  32  loader read data, registered
- ld_done  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  word address to memory
- mem_wdata  out  32  write data to memory
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  32  memory read data, valid on last wait cycle

## Operation
- pipe_req = pipe_r_en | pipe_w_en; both asserted → treated as write.
- Word address = (pipe_addr − BASE_ADDR)[ADDR_W+1:2]; 32-bit subtraction, low two bits dropped, upper bits truncated (out-of-range addresses wrap modulo 2^ADDR_W words; no error).
- States: IDLE, PIPE, PDONE, LD, LDONE.
- IDLE: pipe_req and not (ld_req and ld_turn) → latch addr/data/we, cnt = WAIT_CYCLES−1, go PIPE. Else ld_req → latch loader fields, go LD. Else stay.
- PIPE/LD: mem_addr/mem_wdata driven from latches; mem_we = latched we, mem_re = !latched we, both held every cycle of state. cnt decrements; at cnt==0 capture mem_rdata (reads only) and go PDONE/LDONE.
- PDONE: freeze low for this cycle; → IDLE. LDONE: ld_done=1; → IDLE.
- freeze = pipe_req && state != PDONE (combinational from pipe_req).
- Fairness: ld_turn set on entering PDONE if ld_req high; cleared on entering LD. Pipeline has priority otherwise.
- Loader access in progress while pipe_req rises: freeze stays high until loader completes and the pipe access finishes.
- Reset (any state): state=IDLE, cnt=0, ld_turn=0, pipe_rdata=0, ld_rdata=0, ld_done=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0; partial access abandoned, mem_we drops immediately.

## Timing
- Pipe access latency: request seen in IDLE at cycle 0; PIPE cycles 1..WAIT_CYCLES; PDONE at cycle WAIT_CYCLES+1. freeze high cycles 0..WAIT_CYCLES (WAIT_CYCLES+1 cycles).
- pipe_rdata valid from PDONE cycle and held until the next read completes.
- Back-to-back pipe accesses: one IDLE cycle between PDONE and next PIPE; freeze reasserts in that IDLE cycle.
- Loader: ld_done pulses WAIT_CYCLES+1 cycles after grant from IDLE; ld_rdata held until next loader read.
- All outputs except freeze registered.

## Configuration
- MEM_ACCESS_CTRL_LOADER_EN defined: ld_* ports, LD/LDONE states and ld_turn fairness present.
- Undefined: ld_* ports absent, FSM is IDLE/PIPE/PDONE only, pipeline is sole requester; pipe timing identical.

## Structure
- Package mem_ctrl_pkg: state enum, BASE_ADDR default, WAIT_CYCLES default, DATA_W=32.
- One sub-module: mem_wait_counter (load, decrement, zero flag, 4-bit).

## Test plan
- Reset mid-PIPE write at cycle 2 → mem_we=0 same cycle, state IDLE, pipe_rdata=0, freeze = pipe_req.
- Store pipe_addr=1024+8, data 0xDEADBEEF, WAIT=4 → mem_addr=2, mem_we high cycles 1–4, freeze high cycles 0–4, low cycle 5.
- Load from 1032 after above → pipe_rdata=0xDEADBEEF at PDONE; mem_re high 4 cycles, mem_we low.
- pipe_r_en and pipe_w_en both high → write performed, mem_re never asserted.
- pipe_addr=1020 → mem_addr=0x7FF (wrap), access completes normally.
- Loader enabled: continuous pipe_req plus ld_req → accesses alternate pipe, loader, pipe; ld_done single pulse per loader access; no starvation.
